// File: rtl/cfg_bus_arb.sv
// cfg_bus_arb: two-requester round-robin arbiter in front of a simple
// config bus (one write strobe, one read strobe with a read-valid return).
// Optional read timeout is compiled in when CFG_ARB_TIMEOUT_EN is defined;
// without it the arbiter waits in RD indefinitely and the err outputs are 0.
module cfg_bus_arb #(
  parameter int CFG_DATA_WIDTH = 32,
  parameter int CFG_ADDR_WIDTH = 32,
  parameter int RD_TIMEOUT     = 255
) (
  input  logic                      i_apb_clk,
  input  logic                      i_apb_rst,
  // requester 0
  input  logic                      i_m0_req,
  input  logic                      i_m0_wr,
  input  logic [CFG_ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [CFG_DATA_WIDTH-1:0] i_m0_wr_data,
  output logic                      o_m0_done,
  output logic [CFG_DATA_WIDTH-1:0] o_m0_rd_data,
  output logic                      o_m0_err,
  // requester 1
  input  logic                      i_m1_req,
  input  logic                      i_m1_wr,
  input  logic [CFG_ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [CFG_DATA_WIDTH-1:0] i_m1_wr_data,
  output logic                      o_m1_done,
  output logic [CFG_DATA_WIDTH-1:0] o_m1_rd_data,
  output logic                      o_m1_err,
  // downstream config bus
  output logic                      o_cfg_wr_en,
  output logic [CFG_ADDR_WIDTH-1:0] o_cfg_addr,
  output logic [CFG_DATA_WIDTH-1:0] o_cfg_wr_data,
  output logic                      o_cfg_rd_en,
  input  logic                      i_cfg_rd_vld,
  input  logic [CFG_DATA_WIDTH-1:0] i_cfg_rd_data,
  output logic                      o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state_reg;
  logic   grant_reg;       // requester owning the current transaction
  logic   last_grant_reg;  // requester granted most recently

  logic                      grant_sel;
  logic                      sel_wr;
  logic [CFG_ADDR_WIDTH-1:0] sel_addr;
  logic [CFG_DATA_WIDTH-1:0] sel_wr_data;

  logic                      resp_fire;
  logic [CFG_DATA_WIDTH-1:0] resp_data;
  logic                      resp_err;

`ifdef CFG_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(RD_TIMEOUT);
  logic [15:0] cnt_reg;    // number of RD cycles elapsed, 1 in the first
  logic        m0_err_reg;
  logic        m1_err_reg;
  assign o_m0_err = m0_err_reg;
  assign o_m1_err = m1_err_reg;
`else
  assign o_m0_err = 1'b0;
  assign o_m1_err = 1'b0;
`endif

  // Round-robin pick: a lone request wins, a tie goes to the one not granted last
  always_comb begin
    grant_sel   = (i_m0_req && i_m1_req) ? ~last_grant_reg : i_m1_req;
    sel_wr      = grant_sel ? i_m1_wr      : i_m0_wr;
    sel_addr    = grant_sel ? i_m1_addr    : i_m0_addr;
    sel_wr_data = grant_sel ? i_m1_wr_data : i_m0_wr_data;
  end

  // Decide whether the current transaction completes this cycle and with what result
  always_comb begin
    resp_fire = 1'b0;
    resp_data = '0;
    resp_err  = 1'b0;
    case (state_reg)
      WR: resp_fire = 1'b1;
      RD: begin
        if (i_cfg_rd_vld) begin
          resp_fire = 1'b1;
          resp_data = i_cfg_rd_data;
        end
`ifdef CFG_ARB_TIMEOUT_EN
        else if (cnt_reg == TO_LIMIT) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  // Arbiter FSM with all outputs registered
  always_ff @(posedge i_apb_clk or posedge i_apb_rst) begin
    if (i_apb_rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      o_cfg_wr_en    <= 1'b0;
      o_cfg_rd_en    <= 1'b0;
      o_cfg_addr     <= '0;
      o_cfg_wr_data  <= '0;
      o_busy         <= 1'b0;
      o_m0_done      <= 1'b0;
      o_m1_done      <= 1'b0;
      o_m0_rd_data   <= '0;
      o_m1_rd_data   <= '0;
`ifdef CFG_ARB_TIMEOUT_EN
      cnt_reg        <= '0;
      m0_err_reg     <= 1'b0;
      m1_err_reg     <= 1'b0;
`endif
    end else begin
      o_cfg_wr_en <= 1'b0;
      o_cfg_rd_en <= 1'b0;
      o_m0_done   <= 1'b0;
      o_m1_done   <= 1'b0;
`ifdef CFG_ARB_TIMEOUT_EN
      if (state_reg == RD) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
`endif
      case (state_reg)
        IDLE: begin
          if (i_m0_req || i_m1_req) begin
            grant_reg      <= grant_sel;
            last_grant_reg <= grant_sel;
            o_cfg_addr     <= sel_addr;
            o_cfg_wr_data  <= sel_wr_data;
            o_busy         <= 1'b1;
`ifdef CFG_ARB_TIMEOUT_EN
            cnt_reg        <= 16'd1;
`endif
            if (sel_wr) begin
              state_reg   <= WR;
              o_cfg_wr_en <= 1'b1;
            end else begin
              state_reg   <= RD;
              o_cfg_rd_en <= 1'b1;
            end
          end
        end
        WR, RD: begin
          if (resp_fire) begin
            state_reg <= RESP;
            if (grant_reg) begin
              o_m1_done    <= 1'b1;
              o_m1_rd_data <= resp_data;
`ifdef CFG_ARB_TIMEOUT_EN
              m1_err_reg   <= resp_err;
`endif
            end else begin
              o_m0_done    <= 1'b1;
              o_m0_rd_data <= resp_data;
`ifdef CFG_ARB_TIMEOUT_EN
              m0_err_reg   <= resp_err;
`endif
            end
          end
        end
        RESP: begin
          state_reg <= IDLE;
          o_busy    <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifndef CFG_ARB_TIMEOUT_EN
  // Error result only exists when the timeout is compiled in
  logic unused_err;
  assign unused_err = resp_err;
`endif

endmodule
